// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  // Slot FSM: guard time with everything dark, then the PWM window.
  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } slot_state_e;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] anode_onehot_n(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timing for the display scanner: blank/active slot FSM, PWM step
// counter (prescaled), digit index and the end-of-frame strobe.
module scan_timer
  import display_pkg::*;
#(
  parameter int PRESCALE     = 64,
  parameter int BLANK_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output slot_state_e o_state,
  output logic [1:0]  o_digit,
  output logic [7:0]  o_step,
  output logic        o_slot_start,
  output logic        o_frame_end
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

  slot_state_e      r_state, w_state_nxt;
  logic [BLK_W-1:0] r_blank_cnt, w_blank_cnt_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [7:0]       r_step, w_step_nxt;
  logic [1:0]       r_digit, w_digit_nxt;
  logic             w_blank_last;
  logic             w_active_last;

  assign w_blank_last  = (r_state == ST_BLANK) && (r_blank_cnt == BLK_LAST);
  assign w_active_last = (r_state == ST_ACTIVE) && (r_step == 8'hFF) &&
                         (r_pre == PRE_LAST);

  assign o_state      = r_state;
  assign o_digit      = r_digit;
  assign o_step       = r_step;
  assign o_slot_start = (r_state == ST_BLANK) && (r_blank_cnt == '0);
  assign o_frame_end  = w_active_last && (r_digit == 2'd3);

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_BLANK;
      r_blank_cnt <= '0;
      r_pre       <= '0;
      r_step      <= '0;
      r_digit     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
      r_pre       <= w_pre_nxt;
      r_step      <= w_step_nxt;
      r_digit     <= w_digit_nxt;
    end
  end

  // Next-state: counters wrap straight into the next slot/frame, no idle gap.
  always_comb begin
    w_state_nxt     = r_state;
    w_blank_cnt_nxt = r_blank_cnt;
    w_pre_nxt       = r_pre;
    w_step_nxt      = r_step;
    w_digit_nxt     = r_digit;
    case (r_state)
      ST_BLANK: begin
        if (w_blank_last) begin
          w_state_nxt     = ST_ACTIVE;
          w_blank_cnt_nxt = '0;
          w_pre_nxt       = '0;
          w_step_nxt      = '0;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt + BLK_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (r_pre == PRE_LAST) begin
          w_pre_nxt = '0;
          if (r_step == 8'hFF) begin
            w_state_nxt     = ST_BLANK;
            w_step_nxt      = '0;
            w_blank_cnt_nxt = '0;
            w_digit_nxt     = r_digit + 2'd1;
          end else begin
            w_step_nxt = r_step + 8'd1;
          end
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller with PWM brightness and
// tear-free pattern updates (new patterns are swapped in at frame end).
//
// Update handshake: Seg_In is taken on a rising clock edge where both
// Update_Valid and Update_Ready are high. Update_Ready is low while an
// accepted pattern waits for the frame boundary; it rises on the clock after
// Frame_Done, when the waiting pattern has been moved to the display.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE     = 64,
  parameter int BLANK_CYCLES = 32
) (
  input  logic        Clk_100M,
  input  logic        Reset_Button,
  input  logic [31:0] Seg_In,
  input  logic        Update_Valid,
  output logic        Update_Ready,
  input  logic [7:0]  Brightness,
  output logic [3:0]  SegmentDrivers,
  output logic [7:0]  SevenSegment,
  output logic        Frame_Done
);

  slot_state_e           w_state;
  logic [1:0]            w_digit;
  logic [7:0]            w_step;
  logic                  w_slot_start;
  logic                  w_frame_end;

  logic                  r_pending;
  logic [31:0]           r_pend_buf;
  logic [NUM_DIGITS-1:0][7:0] r_disp;
  logic [7:0]            r_bright;
  logic [3:0]            r_anodes;
  logic [7:0]            r_seg;

  logic                  w_take;
  logic                  w_lit;
  logic [3:0]            w_anodes_nxt;
  logic [7:0]            w_seg_nxt;

  scan_timer #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .i_clk       (Clk_100M),
    .i_rst       (Reset_Button),
    .o_state     (w_state),
    .o_digit     (w_digit),
    .o_step      (w_step),
    .o_slot_start(w_slot_start),
    .o_frame_end (w_frame_end)
  );

  assign Update_Ready   = ~r_pending;
  assign w_take         = Update_Valid & ~r_pending;
  assign Frame_Done     = w_frame_end;
  assign SegmentDrivers = r_anodes;
  assign SevenSegment   = r_seg;

  // Pending buffer and display registers; transfer only at frame end.
  always_ff @(posedge Clk_100M or posedge Reset_Button) begin
    if (Reset_Button) begin
      r_pending  <= 1'b0;
      r_pend_buf <= {4{SEG_BLANK}};
      r_disp     <= {NUM_DIGITS{SEG_BLANK}};
    end else if (w_frame_end && r_pending) begin
      r_disp    <= r_pend_buf;
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_pend_buf <= Seg_In;
      r_pending  <= 1'b1;
    end
  end

  // Brightness is sampled once per slot so a slot's duty never changes midway.
  always_ff @(posedge Clk_100M or posedge Reset_Button) begin
    if (Reset_Button) begin
      r_bright <= 8'h00;
    end else if (w_slot_start) begin
      r_bright <= Brightness;
    end
  end

  // Digit is lit in ACTIVE for PWM steps below the latched brightness.
  always_comb begin
    w_lit        = 1'b0;
    w_anodes_nxt = ANODES_OFF;
    w_seg_nxt    = SEG_BLANK;
    if ((w_state == ST_ACTIVE) && (w_step < r_bright)) begin
      w_lit = 1'b1;
    end
    if (w_lit) begin
      w_anodes_nxt = anode_onehot_n(w_digit);
      w_seg_nxt    = r_disp[w_digit];
    end
  end

  // Registered pin drivers: one clock behind the timer state.
  always_ff @(posedge Clk_100M or posedge Reset_Button) begin
    if (Reset_Button) begin
      r_anodes <= ANODES_OFF;
      r_seg    <= SEG_BLANK;
    end else begin
      r_anodes <= w_anodes_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a short slot (PRESCALE=1,
// BLANK_CYCLES=4: 260-clock slot, 1040-clock frame).
module tb_display_scan_ctrl;

  localparam int PRESCALE     = 1;
  localparam int BLANK_CYCLES = 4;
  localparam int SLOT         = BLANK_CYCLES + 256 * PRESCALE;
  localparam int FRAME        = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg_in = '0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  bright = 8'h00;
  logic [3:0]  anodes;
  logic [7:0]  seg;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {anodes, segments, frame_done} per clock.
  logic [12:0] exp_q[$];
  logic [7:0]  disp_m[4];
  logic [31:0] pend_m;
  bit          pend_vld_m;

  // Clock.
  always #5 clk = ~clk;

  display_scan_ctrl #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .Clk_100M      (clk),
    .Reset_Button  (rst),
    .Seg_In        (seg_in),
    .Update_Valid  (upd_valid),
    .Update_Ready  (upd_ready),
    .Brightness    (bright),
    .SegmentDrivers(anodes),
    .SevenSegment  (seg),
    .Frame_Done    (frame_done)
  );

  // Wait (bounded) for the next Frame_Done, sampled on the falling edge.
  task automatic wait_frame_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Model of the frame-end transfer.
  task automatic model_transfer();
    if (pend_vld_m) begin
      for (int d = 0; d < 4; d++) disp_m[d] = pend_m[8*d +: 8];
      pend_vld_m = 1'b0;
    end
  endtask

  // Expected outputs for the 1040 clocks after a Frame_Done sample.
  // Entry 0 is the trailing off clock of the previous digit 3 slot; then
  // each digit: BLANK_CYCLES off, b[d] lit, rest off; the window ends on
  // the next Frame_Done clock.
  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b[4];
    int         g, d, j;
    bit         on;
    logic [3:0] a;
    logic [7:0] s;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    exp_q.push_back({4'hF, 8'hFF, 1'b0});
    for (int i = 1; i < FRAME; i++) begin
      g  = i - 1;
      d  = g / SLOT;
      j  = g % SLOT;
      on = (j >= BLANK_CYCLES) && ((j - BLANK_CYCLES) < int'(b[d]));
      a  = on ? ~(4'b0001 << d) : 4'hF;
      s  = on ? disp_m[d] : 8'hFF;
      exp_q.push_back({a, s, (i == FRAME - 1)});
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) disp_m[d] = 8'hFF;
    pend_vld_m = 1'b0;
    rst        = 1'b1;
    bright     = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (anodes !== 4'hF || seg !== 8'hFF || upd_ready !== 1'b1 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: got an=%h seg=%h rdy=%b fd=%b, expected an=f seg=ff rdy=1 fd=0",
                 anodes, seg, upd_ready, frame_done);
      end
    end
    rst       = 1'b0;
    seg_in    = 32'hC0F9A4B0;
    upd_valid = 1'b1;
    n_cmp++;
    if (upd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, expected 1", upd_ready);
    end
    @(negedge clk);
    upd_valid  = 1'b0;
    pend_m     = 32'hC0F9A4B0;
    pend_vld_m = 1'b1;
    n_cmp++;
    if (upd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL first_accept_ready: got %b, expected 0", upd_ready);
    end
  endtask

  task automatic test_full_brightness();
    bit          ok;
    logic [12:0] e;
    bright = 8'hFF;
    wait_frame_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL full_sync: got no Frame_Done, expected one"); end
    model_transfer();
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({anodes, seg, frame_done} !== e) begin
        n_err++;
        $display("FAIL full_bright[%0d]: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 i, anodes, seg, frame_done, e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic test_zero_brightness();
    bit          ok;
    logic [12:0] e;
    bright = 8'h00;
    wait_frame_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL zero_sync: got no Frame_Done, expected one"); end
    model_transfer();
    push_frame(8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({anodes, seg, frame_done} !== e) begin
        n_err++;
        $display("FAIL zero_bright[%0d]: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 i, anodes, seg, frame_done, e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic test_partial_duty();
    bit          ok;
    logic [12:0] e;
    bright = 8'h40;
    wait_frame_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL duty_sync: got no Frame_Done, expected one"); end
    model_transfer();
    push_frame(8'h40, 8'h10, 8'h10, 8'h10);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({anodes, seg, frame_done} !== e) begin
        n_err++;
        $display("FAIL partial_duty[%0d]: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 i, anodes, seg, frame_done, e[12:9], e[8:1], e[0]);
      end
      // Change brightness well inside digit 0's lit window.
      if (i == 1 + BLANK_CYCLES + 30) bright = 8'h10;
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    bit          found;
    int          stall_hi;
    logic [31:0] val_a, val_b;
    val_a  = 32'h9282F880;
    val_b  = {8'h80 | 8'($urandom_range(0, 127)), 8'h99, 8'hA1, 8'h8E};
    bright = 8'hFF;
    seg_in    = val_a;
    upd_valid = 1'b1;
    n_cmp++;
    if (upd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_before: got %b, expected 1", upd_ready); end
    @(negedge clk);
    pend_m     = val_a;
    pend_vld_m = 1'b1;
    seg_in     = val_b;
    n_cmp++;
    if (upd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_first_accept: got %b, expected 0", upd_ready); end
    found    = 1'b0;
    stall_hi = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      @(negedge clk);
      if (upd_ready !== 1'b0) stall_hi++;
      if (frame_done === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || stall_hi != 0) begin
      n_err++;
      $display("FAIL b2b_stall: got found=%b ready_high_clocks=%0d, expected found=1 ready_high_clocks=0",
               found, stall_hi);
    end
    model_transfer();
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({anodes, seg, frame_done} !== e) begin
        n_err++;
        $display("FAIL b2b_frame_a[%0d]: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 i, anodes, seg, frame_done, e[12:9], e[8:1], e[0]);
      end
      if (i == 0) begin
        n_cmp++;
        if (upd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_rise: got %b, expected 1", upd_ready); end
      end
      if (i == 1) begin
        n_cmp++;
        if (upd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got %b, expected 0", upd_ready); end
        upd_valid  = 1'b0;
        pend_m     = val_b;
        pend_vld_m = 1'b1;
      end
    end
    // Sitting on the Frame_Done clock: B becomes visible from digit 0 on.
    model_transfer();
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({anodes, seg, frame_done} !== e) begin
        n_err++;
        $display("FAIL b2b_frame_b[%0d]: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 i, anodes, seg, frame_done, e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit          ok;
    logic [12:0] e;
    bright    = 8'hFF;
    seg_in    = 32'h12345678;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid  = 1'b0;
    pend_m     = 32'h12345678;
    pend_vld_m = 1'b1;
    n_cmp++;
    if (upd_ready !== 1'b0) begin n_err++; $display("FAIL mid_pending: got %b, expected 0", upd_ready); end
    // Now one clock past Frame_Done; move into digit 2's lit window.
    repeat (2 * SLOT + BLANK_CYCLES + 100) @(negedge clk);
    n_cmp++;
    if (anodes !== 4'b1011 || seg !== disp_m[2]) begin
      n_err++;
      $display("FAIL mid_digit2_lit: got an=%h seg=%h, expected an=b seg=%h", anodes, seg, disp_m[2]);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (anodes !== 4'hF || seg !== 8'hFF || upd_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_async: got an=%h seg=%h rdy=%b fd=%b, expected an=f seg=ff rdy=1 fd=0",
               anodes, seg, upd_ready, frame_done);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (anodes !== 4'hF || seg !== 8'hFF || upd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mid_reset_hold: got an=%h seg=%h rdy=%b, expected an=f seg=ff rdy=1",
                 anodes, seg, upd_ready);
      end
    end
    rst        = 1'b0;
    pend_vld_m = 1'b0;
    for (int d = 0; d < 4; d++) disp_m[d] = 8'hFF;
    wait_frame_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_sync: got no Frame_Done, expected one"); end
    model_transfer();
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if ({anodes, seg, frame_done} !== e) begin
        n_err++;
        $display("FAIL post_reset_frame[%0d]: got an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
                 i, anodes, seg, frame_done, e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_brightness();
    test_zero_brightness();
    test_partial_duty();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
